// File: rtl/rv_csr_pkg.sv
// Shared CSR indices, port encodings, mstatus field positions and the trap
// sequencer state type, plus the mstatus update rules for trap entry and mret.
package rv_csr_pkg;

    localparam logic [4:0] CSR_MSTATUS  = 5'b00000;
    localparam logic [4:0] CSR_MTVEC    = 5'b00101;
    localparam logic [4:0] CSR_MSCRATCH = 5'b00110;
    localparam logic [4:0] CSR_MEPC     = 5'b01101;
    localparam logic [4:0] CSR_MCAUSE   = 5'b11101;

    localparam logic [1:0] CTL_IDLE = 2'b00;
    localparam logic [1:0] CTL_RD   = 2'b10;
    localparam logic [1:0] CTL_RW1  = 2'b01;
    localparam logic [1:0] CTL_RW2  = 2'b11;

    localparam int MIE_BIT  = 3;
    localparam int MPIE_BIT = 7;
    localparam int MPP_LO   = 11;
    localparam int MPP_HI   = 12;

    // Helpers work on the widest supported XLEN; callers resize.
    localparam int CSR_W = 64;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_T_RDST = 3'd1,
        ST_T_WRA  = 3'd2,
        ST_T_WRB  = 3'd3,
        ST_M_RDST = 3'd4,
        ST_M_WR   = 3'd5,
        ST_M_WAIT = 3'd6,
        ST_REDIR  = 3'd7
    } trap_state_e;

    function automatic logic [CSR_W-1:0] mstatus_on_trap(input logic [CSR_W-1:0] s,
                                                         input logic [1:0]       mpp);
        logic [CSR_W-1:0] r;
        r                = s;
        r[MPIE_BIT]      = s[MIE_BIT];
        r[MIE_BIT]       = 1'b0;
        r[MPP_HI:MPP_LO] = mpp;
        return r;
    endfunction

    function automatic logic [CSR_W-1:0] mstatus_on_mret(input logic [CSR_W-1:0] s);
        logic [CSR_W-1:0] r;
        r           = s;
        r[MIE_BIT]  = s[MPIE_BIT];
        r[MPIE_BIT] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/rv_trap_seq_if.sv
// Bundle between the trap sequencer, the decode/exec stage, the CSR block and
// the PC register; state is exported for observation.
interface rv_trap_seq_if #(
    parameter int XLEN = 32
);
    // trap_req/mret_req are single-cycle pulses, honoured only while busy is
    // low and never queued; redirect_valid is a one-cycle strobe with no
    // back-pressure; csr_rdata follows a read (csr_ctl != 00) by one cycle.
    logic                        trap_req;
    logic [XLEN-1:0]             trap_pc;
    logic [XLEN-1:0]             trap_cause;
    logic                        mret_req;
    logic                        busy;
    logic                        redirect_valid;
    logic [XLEN-1:0]             redirect_pc;
    logic [1:0]                  csr_ctl;
    logic [4:0]                  csr_raddr;
    logic [4:0]                  csr_waddr1;
    logic [XLEN-1:0]             csr_wdata1;
    logic [4:0]                  csr_waddr2;
    logic [XLEN-1:0]             csr_wdata2;
    logic [XLEN-1:0]             csr_rdata;
    rv_csr_pkg::trap_state_e     state;

    modport master (
        input  trap_req, trap_pc, trap_cause, mret_req, csr_rdata,
        output busy, redirect_valid, redirect_pc, csr_ctl, csr_raddr,
               csr_waddr1, csr_wdata1, csr_waddr2, csr_wdata2, state
    );

    modport slave (
        output trap_req, trap_pc, trap_cause, mret_req, csr_rdata,
        input  busy, redirect_valid, redirect_pc, csr_ctl, csr_raddr,
               csr_waddr1, csr_wdata1, csr_waddr2, csr_wdata2, state
    );

endinterface

// File: rtl/rv_trap_seq.sv
// Multi-cycle trap entry / mret sequencer driving the CSR file port and the
// PC redirect; both sequences redirect four cycles after acceptance.
module rv_trap_seq
    import rv_csr_pkg::*;
#(
    parameter int         XLEN     = 32,
    parameter logic [1:0] TRAP_MPP = 2'b11
) (
    input logic          clk,
    input logic          rst,
    rv_trap_seq_if.master bus
);

    trap_state_e     state, state_d;
    logic            busy_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] cause_q;
    logic [XLEN-1:0] mstatus_q;
    logic [XLEN-1:0] target_q;
    logic [XLEN-1:0] trap_mstatus;
    logic [XLEN-1:0] mret_mstatus;

    // mret writes in the same cycle its mstatus read returns, so it uses
    // csr_rdata directly rather than the captured copy.
    assign trap_mstatus = XLEN'(mstatus_on_trap(CSR_W'(mstatus_q), TRAP_MPP));
    assign mret_mstatus = XLEN'(mstatus_on_mret(CSR_W'(bus.csr_rdata)));

    always_comb begin
        state_d = state;
        unique case (state)
            ST_IDLE: begin
                if (bus.trap_req)      state_d = ST_T_RDST;
                else if (bus.mret_req) state_d = ST_M_RDST;
            end
            ST_T_RDST: state_d = ST_T_WRA;
            ST_T_WRA:  state_d = ST_T_WRB;
            ST_T_WRB:  state_d = ST_REDIR;
            ST_M_RDST: state_d = ST_M_WR;
            ST_M_WR:   state_d = ST_M_WAIT;
            ST_M_WAIT: state_d = ST_REDIR;
            ST_REDIR:  state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            busy_q    <= 1'b0;
            pc_q      <= '0;
            cause_q   <= '0;
            mstatus_q <= '0;
            target_q  <= '0;
        end else begin
            state  <= state_d;
            busy_q <= (state_d != ST_IDLE);
            if (state == ST_IDLE && bus.trap_req) begin
                pc_q    <= bus.trap_pc;
                cause_q <= bus.trap_cause;
            end
            if (state == ST_T_WRA || state == ST_M_WR)
                mstatus_q <= bus.csr_rdata;
            // Vectored mtvec is not supported: the mode bits are dropped.
            if (state == ST_T_WRB)
                target_q <= {bus.csr_rdata[XLEN-1:2], 2'b00};
            if (state == ST_M_WAIT)
                target_q <= bus.csr_rdata;
        end
    end

    always_comb begin
        bus.csr_ctl    = CTL_IDLE;
        bus.csr_raddr  = 5'd0;
        bus.csr_waddr1 = 5'd0;
        bus.csr_wdata1 = '0;
        bus.csr_waddr2 = 5'd0;
        bus.csr_wdata2 = '0;
        unique case (state)
            ST_T_RDST, ST_M_RDST: begin
                bus.csr_ctl   = CTL_RD;
                bus.csr_raddr = CSR_MSTATUS;
            end
            ST_T_WRA: begin
                bus.csr_ctl    = CTL_RW2;
                bus.csr_raddr  = CSR_MTVEC;
                bus.csr_waddr1 = CSR_MEPC;
                bus.csr_wdata1 = pc_q;
                bus.csr_waddr2 = CSR_MCAUSE;
                bus.csr_wdata2 = cause_q;
            end
            ST_T_WRB: begin
                bus.csr_ctl    = CTL_RW1;
                bus.csr_waddr1 = CSR_MSTATUS;
                bus.csr_wdata1 = trap_mstatus;
            end
            ST_M_WR: begin
                bus.csr_ctl    = CTL_RW1;
                bus.csr_raddr  = CSR_MEPC;
                bus.csr_waddr1 = CSR_MSTATUS;
                bus.csr_wdata1 = mret_mstatus;
            end
            default: begin
            end
        endcase
    end

    assign bus.busy           = busy_q;
    assign bus.redirect_valid = (state == ST_REDIR);
    assign bus.redirect_pc    = (state == ST_REDIR) ? target_q : '0;
    assign bus.state          = state;

endmodule

// File: tb/tb_rv_trap_seq.sv
// Bench for rv_trap_seq: behavioural CSR block, reference model of the
// trap/mret rules, and a scoreboard fed at issue time and drained by a monitor.
module tb_rv_trap_seq;
    import rv_csr_pkg::*;

    logic clk;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    rv_trap_seq_if #(.XLEN(32)) bus ();

    rv_trap_seq #(.XLEN(32), .TRAP_MPP(2'b11)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural CSR block: registered read, read-before-write.
    logic [31:0] csr [32];
    logic        csr_clr;
    logic        poke_en;
    logic [31:0] poke_ms, poke_tv, poke_ep, poke_sc;

    always @(posedge clk) begin
        if (csr_clr) begin
            for (int i = 0; i < 32; i++) csr[i] <= '0;
            bus.csr_rdata <= '0;
        end else if (poke_en) begin
            csr[CSR_MSTATUS]  <= poke_ms;
            csr[CSR_MTVEC]    <= poke_tv;
            csr[CSR_MEPC]     <= poke_ep;
            csr[CSR_MSCRATCH] <= poke_sc;
        end else begin
            if (bus.csr_ctl != 2'b00) bus.csr_rdata <= csr[bus.csr_raddr];
            if (bus.csr_ctl[0])       csr[bus.csr_waddr1] <= bus.csr_wdata1;
            if (bus.csr_ctl == 2'b11) csr[bus.csr_waddr2] <= bus.csr_wdata2;
        end
    end

    logic [36:0] exp_wr_q [$];
    logic [63:0] exp_rd_q [$];
    int          redir_cyc_q [$];
    int          busy_lo = 1;
    int          busy_hi = 0;

    function automatic logic [31:0] ref_trap(input logic [31:0] ms);
        return (ms & ~32'h0000_1888) | 32'h0000_1800 | (((ms >> 3) & 32'h1) << 7);
    endfunction

    function automatic logic [31:0] ref_mret(input logic [31:0] ms);
        return (ms & ~32'h0000_0088) | 32'h0000_0080 | (((ms >> 7) & 32'h1) << 3);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [31:0] ms, input logic [31:0] tv,
                           input logic [31:0] ep, input logic [31:0] sc);
        poke_ms = ms; poke_tv = tv; poke_ep = ep; poke_sc = sc;
        poke_en = 1'b1;
        tick();
        poke_en = 1'b0;
    endtask

    // Drives one request from IDLE and returns on the first edge that can
    // accept the next one; spam>0 re-pulses a request that many cycles in.
    task automatic issue(input logic t, input logic m, input logic [31:0] pc,
                         input logic [31:0] cause, input int spam);
        int c;
        c = cyc;
        bus.trap_req = t; bus.mret_req = m;
        bus.trap_pc = pc; bus.trap_cause = cause;
        if (t) begin
            exp_wr_q.push_back({CSR_MEPC, pc});
            exp_wr_q.push_back({CSR_MCAUSE, cause});
            exp_wr_q.push_back({CSR_MSTATUS, ref_trap(csr[CSR_MSTATUS])});
            exp_rd_q.push_back({32'(c + 4), csr[CSR_MTVEC] & ~32'h3});
        end else if (m) begin
            exp_wr_q.push_back({CSR_MSTATUS, ref_mret(csr[CSR_MSTATUS])});
            exp_rd_q.push_back({32'(c + 4), csr[CSR_MEPC]});
        end
        if (t || m) begin
            busy_lo = c + 1;
            busy_hi = c + 4;
        end
        tick();
        for (int k = 1; k <= 4; k++) begin
            bus.trap_req   = (k == spam) ? 1'b1 : 1'b0;
            bus.mret_req   = (k == spam) ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.trap_pc    = $urandom;
            bus.trap_cause = $urandom;
            tick();
        end
        bus.trap_req = 1'b0;
        bus.mret_req = 1'b0;
    endtask

    logic [36:0] ew;
    logic [63:0] er;
    logic [31:0] ms0, sc_val;
    int          c0;

    initial begin
        rst = 1'b1;
        csr_clr = 1'b1;
        poke_en = 1'b0;
        poke_ms = '0; poke_tv = '0; poke_ep = '0; poke_sc = '0;
        bus.trap_req = 1'b0; bus.mret_req = 1'b0;
        bus.trap_pc = '0; bus.trap_cause = '0;

        fork
            forever begin
                @(negedge clk);
                chk("busy", 64'(bus.busy), 64'((cyc >= busy_lo) && (cyc <= busy_hi)));
                if (bus.csr_ctl[0]) begin
                    if (exp_wr_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL wr1_unexpected actual=%h:%h expected=none", bus.csr_waddr1, bus.csr_wdata1);
                    end else begin
                        ew = exp_wr_q.pop_front();
                        chk("wr1", 64'({bus.csr_waddr1, bus.csr_wdata1}), 64'(ew));
                    end
                end
                if (bus.csr_ctl == 2'b11) begin
                    if (exp_wr_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL wr2_unexpected actual=%h:%h expected=none", bus.csr_waddr2, bus.csr_wdata2);
                    end else begin
                        ew = exp_wr_q.pop_front();
                        chk("wr2", 64'({bus.csr_waddr2, bus.csr_wdata2}), 64'(ew));
                    end
                end
                if (bus.redirect_valid) begin
                    redir_cyc_q.push_back(cyc);
                    if (exp_rd_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL redirect_unexpected actual=%h expected=none", bus.redirect_pc);
                    end else begin
                        er = exp_rd_q.pop_front();
                        chk("redirect_pc", 64'(bus.redirect_pc), 64'(er[31:0]));
                        chk("redirect_cyc", 64'(cyc), 64'(er[63:32]));
                    end
                end
            end
        join_none

        tick();
        csr_clr = 1'b0;
        tick();
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_redirect_valid", 64'(bus.redirect_valid), 64'd0);
        chk("rst_redirect_pc", 64'(bus.redirect_pc), 64'd0);
        chk("rst_csr_ctl", 64'(bus.csr_ctl), 64'd0);
        chk("rst_raddr", 64'(bus.csr_raddr), 64'd0);
        chk("rst_waddr1", 64'(bus.csr_waddr1), 64'd0);
        chk("rst_wdata1", 64'(bus.csr_wdata1), 64'd0);
        chk("rst_waddr2", 64'(bus.csr_waddr2), 64'd0);
        chk("rst_wdata2", 64'(bus.csr_wdata2), 64'd0);
        rst = 1'b0;
        tick();

        sc_val = $urandom;
        // Directed trap entry.
        preload(32'h0000_0008, 32'h8000_1001, 32'h0, sc_val);
        issue(1'b1, 1'b0, 32'h8000_0100, 32'd11, 0);
        chk("t1_mepc", 64'(csr[CSR_MEPC]), 64'h8000_0100);
        chk("t1_mcause", 64'(csr[CSR_MCAUSE]), 64'h0000_000B);
        chk("t1_mstatus", 64'(csr[CSR_MSTATUS]), 64'h0000_1880);

        // Directed mret.
        preload(32'h0000_1880, 32'h8000_1001, 32'h8000_0104, sc_val);
        issue(1'b0, 1'b1, 32'h0, 32'h0, 0);
        chk("t2_mstatus", 64'(csr[CSR_MSTATUS]), 64'h0000_1888);

        // Simultaneous requests: trap only.
        preload(32'h0000_0008, 32'h4000_0203, 32'h1234_5678, sc_val);
        issue(1'b1, 1'b1, 32'h0000_2000, 32'd3, 0);
        chk("t3_mepc", 64'(csr[CSR_MEPC]), 64'h0000_2000);
        chk("t3_mcause", 64'(csr[CSR_MCAUSE]), 64'h0000_0003);
        chk("t3_mstatus", 64'(csr[CSR_MSTATUS]), 64'h0000_1880);

        // Second trap pulse during T_WRA is ignored.
        preload(32'h0000_0000, 32'h0000_0100, 32'h0, sc_val);
        issue(1'b1, 1'b0, 32'hCAFE_0000, 32'd2, 2);
        repeat (3) tick();
        chk("t4_mepc", 64'(csr[CSR_MEPC]), 64'hCAFE_0000);
        chk("t4_pulses", 64'(redir_cyc_q.size()), 64'd4);

        // Reset in T_WRA aborts the sequence.
        preload(32'h0000_0008, 32'h0000_0400, 32'h0, sc_val);
        ms0 = csr[CSR_MSTATUS];
        c0 = cyc;
        bus.trap_req = 1'b1; bus.trap_pc = 32'h0000_0AA0; bus.trap_cause = 32'd7;
        busy_lo = c0 + 1;
        busy_hi = c0 + 1;
        tick();
        bus.trap_req = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        chk("t5_busy", 64'(bus.busy), 64'd0);
        chk("t5_csr_ctl", 64'(bus.csr_ctl), 64'd0);
        chk("t5_redirect_valid", 64'(bus.redirect_valid), 64'd0);
        tick();
        rst = 1'b0;
        repeat (6) tick();
        chk("t5_mstatus", 64'(csr[CSR_MSTATUS]), 64'(ms0));
        chk("t5_pulses", 64'(redir_cyc_q.size()), 64'd4);

        // Back-to-back trap then mret on the first free edge.
        preload(32'h0000_0008, 32'h0000_8001, 32'h0, sc_val);
        issue(1'b1, 1'b0, 32'h0000_0F00, 32'd8, 0);
        issue(1'b0, 1'b1, 32'h0, 32'h0, 0);
        chk("t6_spacing", 64'(redir_cyc_q[redir_cyc_q.size() - 1] - redir_cyc_q[redir_cyc_q.size() - 2]), 64'd5);
        chk("t6_mstatus", 64'(csr[CSR_MSTATUS]), 64'h0000_1888);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 2) == 0)
                preload($urandom, $urandom, $urandom, sc_val);
            case ($urandom_range(0, 2))
                0:       issue(1'b1, 1'b0, $urandom, $urandom, $urandom_range(0, 4));
                1:       issue(1'b0, 1'b1, $urandom, $urandom, $urandom_range(0, 4));
                default: issue(1'b1, 1'b1, $urandom, $urandom, $urandom_range(0, 4));
            endcase
            repeat ($urandom_range(0, 3)) tick();
        end

        for (int k = 0; k < 20 && (exp_wr_q.size() != 0 || exp_rd_q.size() != 0); k++) tick();
        chk("drain_wr", 64'(exp_wr_q.size()), 64'd0);
        chk("drain_rd", 64'(exp_rd_q.size()), 64'd0);
        chk("mscratch", 64'(csr[CSR_MSCRATCH]), 64'(sc_val));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rv_trap_seq.md
Name: rv_trap_seq

Overview:
- Multi-cycle trap/return sequencer. It drives the initiator side of the CPU's CSR file port.
- On an ecall-style trap request it performs the following, then redirects the PC to mtvec:
  - saves the PC into mepc
  - writes the cause into mcause
  - updates mstatus
- On mret it restores mstatus and redirects the PC to mepc.
- It sits between the decode/exec stage, which raises requests and is stalled by busy, and the CSR register block plus the PC register.

Parameters:
- XLEN, 32, data and address width of the PC, cause and CSR data.
- TRAP_MPP, 2'b11, value written to mstatus.MPP on trap entry (M-mode only).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- trap_req  in  1  trap request pulse; sampled only in IDLE
- trap_pc  in  XLEN  PC of the trapping instruction; sampled with trap_req
- trap_cause  in  XLEN  mcause value; sampled with trap_req
- mret_req  in  1  mret request pulse; sampled only in IDLE
- busy  out  1  high in every non-IDLE state; the core stalls on it
- redirect_valid  out  1  one-cycle pulse: the PC must load redirect_pc
- redirect_pc  out  XLEN  new PC target
- csr_ctl  out  2  CSR port control:
  - 00 idle
  - 10 read only
  - 01 read plus write port 1
  - 11 read plus writes on ports 1 and 2
- csr_raddr  out  5  CSR read index
- csr_waddr1  out  5  write port 1 index
- csr_wdata1  out  XLEN  write port 1 data
- csr_waddr2  out  5  write port 2 index
- csr_wdata2  out  XLEN  write port 2 data
- csr_rdata  in  XLEN  CSR read data. It is registered by the CSR block and valid in the cycle after csr_ctl != 00 with csr_raddr presented. A read in the same cycle as a write returns the old value.

Behaviour:
- CSR indices:
  - mstatus 5'b00000
  - mtvec 5'b00101
  - mscratch 5'b00110
  - mepc 5'b01101
  - mcause 5'b11101
- FSM states: IDLE, T_RDST, T_WRA, T_WRB, M_RDST, M_WR, M_WAIT, REDIR.
- CSR outputs are combinational from state and internal registers. csr_ctl=00 and all addresses/data are 0 in IDLE and REDIR.
- IDLE transitions:
  - trap_req=1: latch trap_pc and trap_cause, go to T_RDST.
  - else mret_req=1: go to M_RDST.
  - Both high at once: trap wins and mret is dropped.
- T_RDST: ctl=10, raddr=mstatus. Next state T_WRA.
- T_WRA:
  - Capture csr_rdata into mstatus_q.
  - ctl=11: waddr1=mepc, wdata1=latched pc; waddr2=mcause, wdata2=latched cause.
  - raddr=mtvec.
  - Next state T_WRB.
- T_WRB:
  - Capture target = {csr_rdata[XLEN-1:2], 2'b00}. Only direct mode is supported.
  - ctl=01: waddr1=mstatus, wdata1 = mstatus_q with MPIE(bit 7)=old MIE(bit 3), MIE=0, MPP(bits 12:11)=TRAP_MPP.
  - Next state REDIR.
- M_RDST: ctl=10, raddr=mstatus. Next state M_WR.
- M_WR:
  - Capture mstatus_q.
  - ctl=01: waddr1=mstatus, wdata1 = mstatus_q with MIE=old MPIE, MPIE=1.
  - raddr=mepc.
  - Next state M_WAIT.
- M_WAIT: ctl=00; capture target = csr_rdata unmodified. Next state REDIR.
- REDIR: redirect_valid=1, redirect_pc=target. Next state IDLE.
- Latency:
  - redirect_valid is high in the 4th cycle after the accepting edge, for both trap and mret.
  - A new request can be accepted on the 5th edge.
- Requests in non-IDLE states are ignored; they are not queued.
- busy is registered state decode. It is low in IDLE only.
- Reset values: state IDLE, busy=0, redirect_valid=0, redirect_pc=0, csr_ctl=00, all CSR address/data outputs 0, internal latches 0.
- Reset mid-sequence aborts immediately. No further CSR writes or redirect are issued. Writes already issued stand.

Decomposition:
- Package rv_csr_pkg holds:
  - CSR index constants
  - csr_ctl encodings
  - mstatus bit positions (MIE=3, MPIE=7, MPP=12:11)
  - FSM state enum
  - functions mstatus_on_trap and mstatus_on_mret
- Single module, no sub-module. The next-state logic is small enough inline.

Test Plan:
- Trap, mstatus=0x00000008, mtvec=0x80001001, trap_pc=0x80000100, cause=11 -> the following, with busy high 4 cycles:
  - mepc=0x80000100
  - mcause=0x0000000B
  - mstatus=0x00001880
  - redirect_valid in cycle 4 with redirect_pc=0x80001000
- mret, mstatus=0x00001880, mepc=0x80000104 -> mstatus=0x00001888 and redirect_pc=0x80000104 in cycle 4.
- trap_req and mret_req asserted together -> trap sequence only; mepc and mcause written, no mret behaviour.
- trap_req pulsed again during T_WRA -> ignored; exactly one redirect_valid pulse; mepc holds the first pc.
- rst asserted in T_WRA -> next cycle IDLE, csr_ctl=00, no redirect_valid, mstatus not updated.
- Back-to-back trap then mret accepted on the first free edge -> two redirect pulses exactly 5 cycles apart, with correct targets.
